rp_product_accumulator: RTL and testbench
=========================================

# rp_product_accumulator

Sequential accumulation stage directly downstream of the 8-bit unsigned Russian-peasant multiplier. It consumes a stream of 16-bit products over a valid/ready handshake and sums them into a wide accumulator. A frame is delimited by `in_last`. At the end of a frame it presents the sum, the product count and an overflow flag on a registered output handshake.

## Interface
- `PROD_W`, 16, product width (multiplier output width).
- `ACC_W`, 24, accumulator width; must be ≥ `PROD_W`.
- `CNT_W`, 9, product-counter width.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `clr`  in  1  synchronous frame abort; clears accumulator and count.
- `in_valid`  in  1  product valid.
- `in_ready`  out  1  stage can accept a product.
- `in_product`  in  PROD_W  unsigned product from the multiplier.
- `in_last`  in  1  marks the final product of a frame.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_acc`  out  ACC_W  frame sum.
- `out_count`  out  CNT_W  number of products in the frame.
- `out_ovf`  out  1  sticky: the sum exceeded 2^ACC_W−1 during the frame.

## Operation
- The FSM has two states: ACC and HOLD. Reset enters ACC.
- ACC state:
  - `in_ready`=1 and `out_valid`=0.
  - An input handshake (`in_valid`&`in_ready`) updates `acc` ← `acc` + zero-extended `in_product` and `cnt` ← `cnt`+1.
  - If the addition carries out of ACC_W, `ovf` ← 1.
  - When `cnt` reaches 2^CNT_W−1 it saturates there.
- Handshake with `in_last`=1: the updated `acc`/`cnt`/`ovf` are loaded into the output registers and the FSM moves to HOLD. The internal `acc`, `cnt` and `ovf` clear in the same edge.
- HOLD state:
  - `in_ready`=0 and `out_valid`=1.
  - `out_acc`, `out_count` and `out_ovf` are held stable.
  - An output handshake (`out_valid`&`out_ready`) returns the FSM to ACC.
- `clr`=1 in ACC: `acc`, `cnt` and `ovf` clear. Any input handshake in that cycle is discarded, `in_last` included.
- `clr`=1 in HOLD: ignored. The pending result is never dropped.
- Arithmetic is unsigned with ACC_W+1-bit internal addition; bit ACC_W is the carry.
- A frame of one product (`in_last` on the first beat) is legal and yields count 1.
- Zero products are accumulated normally and count toward `out_count`.

## Timing
- Reset values:
  - `in_ready`=1 (combinational from state ACC).
  - `out_valid`=0.
  - `out_acc`=0, `out_count`=0, `out_ovf`=0.
  - Internal `acc`, `cnt` and `ovf` = 0.
- Latency: the last input handshake at edge T gives `out_valid`=1 after edge T.
- Back-to-back frames: an output handshake at edge T gives `in_ready`=1 after T. This costs one bubble cycle per frame.
- Handshake outputs: `in_ready` and `out_valid` depend only on state, never combinationally on `in_valid` or `out_ready`.
- Reset mid-frame or mid-HOLD: state, accumulator and outputs return to reset values immediately. A partial frame is lost.

## Configuration
- `RP_ACC_SATURATE_EN` defined:
  - On carry-out, `acc` clamps to 2^ACC_W−1.
  - Further additions keep it clamped.
  - `ovf` is set.
- `RP_ACC_SATURATE_EN` undefined:
  - `acc` wraps modulo 2^ACC_W.
  - `ovf` is still set.

## Test plan
- Reset, then products 11270, 16830, 9618 with `in_last` on the third, `out_ready`=1 → `out_acc`=37718, `out_count`=3, `out_ovf`=0. `out_valid` is high exactly one cycle.
- Same frame with `out_ready`=0 for 5 cycles → `out_valid` held, `in_ready`=0, outputs stable. The next frame's first product is accepted only after the output handshake.
- 259 products of 65025, last flagged:
  - `RP_ACC_SATURATE_EN` undefined → `out_acc`=64259, `out_count`=259, `out_ovf`=1.
  - `RP_ACC_SATURATE_EN` defined → `out_acc`=16777215, `out_count`=259, `out_ovf`=1.
- Two products (100, 200), then `clr` together with a valid product 300 (no last), then product 5 with last → `out_acc`=5, `out_count`=1.
- Single product 0 with `in_last` → `out_acc`=0, `out_count`=1. `rst_n` pulsed low mid-frame after two products → all outputs 0, `in_ready`=1. A following single-product frame of 7 → `out_acc`=7, `out_count`=1.

Source files
------------

// File: rtl/rp_product_accumulator_if.sv
// Handshake bundle between the product stream source, the accumulator stage and the result consumer.
interface rp_product_accumulator_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 9
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_product, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_product, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_ovf
    );
endinterface

// File: rtl/rp_product_accumulator.sv
// Frame-based accumulator for 16-bit multiplier products with a registered result handshake.
// Define RP_ACC_SATURATE_EN to clamp the sum at its maximum instead of wrapping on overflow.
module rp_product_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 9
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    rp_product_accumulator_if.slave   bus
);

    typedef enum logic {ST_ACC, ST_HOLD} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_acc_q, out_acc_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [ACC_W:0]     sum;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt_next;
    logic               ovf_next;

    // Bit ACC_W of the widened sum is the carry that flags overflow.
    always_comb begin
        sum = {1'b0, acc_q} + (ACC_W+1)'(bus.in_product);
`ifdef RP_ACC_SATURATE_EN
        acc_next = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
`else
        acc_next = sum[ACC_W-1:0];
`endif
        ovf_next = ovf_q | sum[ACC_W];
        cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_ACC: begin
                if (clr) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (bus.in_valid) begin
                    if (bus.in_last) begin
                        out_acc_d   = acc_next;
                        out_count_d = cnt_next;
                        out_ovf_d   = ovf_next;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = ST_HOLD;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end else begin
                        acc_d = acc_next;
                        cnt_d = cnt_next;
                        ovf_d = ovf_next;
                    end
                end
            end
            // The held result survives clr; only the consumer can release it.
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d     = ST_ACC;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_ACC;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_rp_product_accumulator.sv
// Self-checking bench for rp_product_accumulator: frame-sum model plus directed frames with literal results.
module tb_rp_product_accumulator;

    typedef struct {
        logic [23:0] acc;
        logic [8:0]  cnt;
        logic        ovf;
    } res_t;

    localparam longint ACC_MAX_L = (64'd1 << 24) - 1;
    localparam longint CNT_MAX_L = 511;

    logic clk;
    logic rst_n;
    logic clr;

    rp_product_accumulator_if bus ();

    rp_product_accumulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    int      vecCount;
    int      missCount;
    res_t    expQ[$];
    longint  frameSum;
    longint  frameN;
    int      framesDone;
    int      curValid;
    int      lastValidCycles;
    res_t    lastRes;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // The frame result follows directly from the arithmetic sum of its products.
    function automatic res_t frameResult(input longint total, input longint n);
        res_t r;
`ifdef RP_ACC_SATURATE_EN
        r.acc = (total > ACC_MAX_L) ? 24'(ACC_MAX_L) : 24'(total);
`else
        r.acc = 24'(total % (ACC_MAX_L + 1));
`endif
        r.cnt = (n > CNT_MAX_L) ? 9'(CNT_MAX_L) : 9'(n);
        r.ovf = (total > ACC_MAX_L);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
            checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
            checkOutput("rst_out_acc",   32'(bus.out_acc),   32'd0);
            checkOutput("rst_out_count", 32'(bus.out_count), 32'd0);
            checkOutput("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
            expQ.delete();
            frameSum = 0;
            frameN   = 0;
            curValid = 0;
        end else begin
            bit expHold;
            expHold = (expQ.size() != 0);
            checkOutput("in_ready",  32'(bus.in_ready),  32'(!expHold));
            checkOutput("out_valid", 32'(bus.out_valid), 32'(expHold));
            if (expHold) begin
                checkOutput("out_acc",   32'(bus.out_acc),   32'(expQ[0].acc));
                checkOutput("out_count", 32'(bus.out_count), 32'(expQ[0].cnt));
                checkOutput("out_ovf",   32'(bus.out_ovf),   32'(expQ[0].ovf));
                curValid++;
                if (bus.out_ready) begin
                    lastRes         = expQ.pop_front();
                    lastValidCycles = curValid;
                    curValid        = 0;
                    framesDone++;
                end
            end else if (clr) begin
                frameSum = 0;
                frameN   = 0;
            end else if (bus.in_valid) begin
                frameSum += longint'(bus.in_product);
                frameN++;
                if (bus.in_last) begin
                    expQ.push_back(frameResult(frameSum, frameN));
                    frameSum = 0;
                    frameN   = 0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] product, input logic last, input logic clrv);
        bit accepted;
        accepted = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_product = product;
        bus.in_last    = last;
        clr            = clrv;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            accepted = bus.in_ready;
            @(posedge clk);
            #1;
            if (accepted) break;
        end
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        clr          = 1'b0;
    endtask

    task automatic waitFrame(input int target);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (framesDone >= target) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) checkOutput("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkFrame(input string name, input int acc, input int cnt, input int ovf);
        checkOutput({name, "_acc"}, 32'(lastRes.acc), 32'(acc));
        checkOutput({name, "_cnt"}, 32'(lastRes.cnt), 32'(cnt));
        checkOutput({name, "_ovf"}, 32'(lastRes.ovf), 32'(ovf));
    endtask

    initial begin
        vecCount = 0; missCount = 0; framesDone = 0; curValid = 0; lastValidCycles = 0;
        frameSum = 0; frameN = 0;
        rst_n = 1'b1; clr = 1'b0;
        bus.in_valid = 1'b0; bus.in_product = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        applyStimulus(16'd11270, 1'b0, 1'b0);
        applyStimulus(16'd16830, 1'b0, 1'b0);
        applyStimulus(16'd9618,  1'b1, 1'b0);
        waitFrame(1);
        checkFrame("basic", 37718, 3, 0);
        checkOutput("basic_valid_cycles", 32'(lastValidCycles), 32'd1);

        bus.out_ready = 1'b0;
        applyStimulus(16'd11270, 1'b0, 1'b0);
        applyStimulus(16'd16830, 1'b0, 1'b0);
        applyStimulus(16'd9618,  1'b1, 1'b0);
        fork
            applyStimulus(16'd1000, 1'b1, 1'b0);
            begin
                repeat (5) @(negedge clk);
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        waitFrame(3);
        checkFrame("next_after_hold", 1000, 1, 0);

        for (int i = 0; i < 259; i++) applyStimulus(16'd65025, (i == 258), 1'b0);
        waitFrame(4);
`ifdef RP_ACC_SATURATE_EN
        checkFrame("overflow", 16777215, 259, 1);
`else
        checkFrame("overflow", 64259, 259, 1);
`endif

        applyStimulus(16'd100, 1'b0, 1'b0);
        applyStimulus(16'd200, 1'b0, 1'b0);
        applyStimulus(16'd300, 1'b0, 1'b1);
        applyStimulus(16'd5,   1'b1, 1'b0);
        waitFrame(5);
        checkFrame("clr", 5, 1, 0);

        applyStimulus(16'd0, 1'b1, 1'b0);
        waitFrame(6);
        checkFrame("zero", 0, 1, 0);

        applyStimulus(16'd1, 1'b0, 1'b0);
        applyStimulus(16'd2, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_count", 32'(bus.out_count), 32'd0);
        checkOutput("midrst_ready", 32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(16'd7, 1'b1, 1'b0);
        waitFrame(7);
        checkFrame("after_rst", 7, 1, 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    // The hold-phase check needs the first held frame, captured before the 1000 frame overwrites it.
    initial begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (framesDone >= 2) begin
                seen = 1'b1;
                checkFrame("hold", 37718, 3, 0);
                checkOutput("hold_valid_cycles", 32'(lastValidCycles), 32'd6);
            end
        end
    end

endmodule
